// File: rtl/wb_nor_flash.sv
// Read-only Wishbone B3 slave for an asynchronous parallel NOR flash.
// Page-mode reads, 16/32-bit flash data, open-page reuse for linear bursts.
module wb_nor_flash #(
  parameter int FLASH_DW   = 16,
  parameter int FLASH_AW   = 25,
  parameter int WAIT_FIRST = 8,
  parameter int WAIT_PAGE  = 3,
  parameter int PAGE_WORDS = 16,
  parameter int RST_CYCLES = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [2:0]          wb_cti_i,
  input  logic [1:0]          wb_bte_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  input  logic [FLASH_DW-1:0] flash_dat_i,
  output logic [FLASH_AW-1:0] flash_adr_o,
  output logic                flash_csn_o,
  output logic                flash_oen_o,
  output logic                flash_wen_o,
  output logic                flash_advn_o,
  output logic                flash_clk_o,
  output logic                flash_rstn_o
);

  localparam int PG_W = $clog2(PAGE_WORDS);
  localparam int CW   = 16;

  typedef enum logic [2:0] {S_RST, S_IDLE, S_ACC, S_ACK, S_GAP, S_ERR} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [FLASH_AW-1:0] adr_q;
  logic                csn_q, oen_q, rstn_q, ack_q, err_q, half_q, abort_q;
  logic [15:0]         hi_q;
  logic [31:0]         dat_q;

  logic [FLASH_AW-1:0] adr_d, nxt_adr_s;
  logic [31:0]         fdat_s, rd_word_s;
  logic                rd_s, wr_s, same_pg_s, nxt_same_s, last_half_s;
  logic                unused_s;

  assign rd_s        = wb_cyc_i & wb_stb_i & ~wb_we_i;
  assign wr_s        = wb_cyc_i & wb_stb_i & wb_we_i;
  assign fdat_s      = 32'(flash_dat_i);
  assign nxt_adr_s   = adr_q + FLASH_AW'(1);
  assign same_pg_s   = (adr_d[FLASH_AW-1:PG_W] == adr_q[FLASH_AW-1:PG_W]);
  assign nxt_same_s  = (nxt_adr_s[FLASH_AW-1:PG_W] == adr_q[FLASH_AW-1:PG_W]);
  assign last_half_s = (FLASH_DW == 32) ? 1'b1 : half_q;
  assign rd_word_s   = (FLASH_DW == 16) ? {hi_q, fdat_s[15:0]} : fdat_s;
  assign unused_s    = ^{wb_dat_i, wb_sel_i, wb_bte_i, wb_adr_i, fdat_s};

  // Byte address to flash word address; upper bits are dropped, so accesses alias
  always_comb begin
    adr_d = '0;
    if (FLASH_DW == 16) begin
      adr_d = {wb_adr_i[FLASH_AW:2], 1'b0};
    end else begin
      adr_d = wb_adr_i[FLASH_AW+1:2];
    end
  end

  // Bridge FSM; every flash and bus output is a register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      adr_q   <= '0;
      csn_q   <= 1'b1;
      oen_q   <= 1'b1;
      rstn_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      half_q  <= 1'b0;
      abort_q <= 1'b0;
      hi_q    <= 16'h0000;
      dat_q   <= 32'h0000_0000;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_RST: begin
          if (cnt_q == CW'(RST_CYCLES - 1)) begin
            rstn_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_IDLE: begin
          csn_q <= 1'b1;
          oen_q <= 1'b1;
          if (wr_s) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else if (rd_s) begin
            adr_q   <= adr_d;
            csn_q   <= 1'b0;
            oen_q   <= 1'b0;
            cnt_q   <= CW'(WAIT_FIRST - 1);
            half_q  <= 1'b0;
            abort_q <= 1'b0;
            state_q <= S_ACC;
          end
        end
        S_ERR: state_q <= S_IDLE;
        S_ACC: begin
          if (!wb_cyc_i) abort_q <= 1'b1;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            hi_q <= fdat_s[15:0];
            // An abandoned cycle lets the current flash access finish but never acks
            if (abort_q || !(wb_cyc_i && wb_stb_i)) begin
              csn_q   <= 1'b1;
              oen_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (!last_half_s) begin
              adr_q  <= nxt_adr_s;
              half_q <= 1'b1;
              cnt_q  <= nxt_same_s ? CW'(WAIT_PAGE - 1) : CW'(WAIT_FIRST - 1);
            end else begin
              dat_q   <= rd_word_s;
              ack_q   <= 1'b1;
              state_q <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (wb_cti_i == 3'b010) begin
            state_q <= S_GAP;
          end else begin
            csn_q   <= 1'b1;
            oen_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          // Next burst beat keeps the page open when it lands in the last driven page
          if (rd_s) begin
            adr_q   <= adr_d;
            cnt_q   <= same_pg_s ? CW'(WAIT_PAGE - 1) : CW'(WAIT_FIRST - 1);
            half_q  <= 1'b0;
            abort_q <= 1'b0;
            state_q <= S_ACC;
          end else begin
            csn_q   <= 1'b1;
            oen_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          csn_q   <= 1'b1;
          oen_q   <= 1'b1;
          rstn_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_RST;
        end
      endcase
    end
  end

  assign wb_dat_o     = dat_q;
  assign wb_ack_o     = ack_q;
  assign wb_err_o     = err_q;
  assign flash_adr_o  = adr_q;
  assign flash_csn_o  = csn_q;
  assign flash_oen_o  = oen_q;
  assign flash_wen_o  = 1'b1;
  assign flash_advn_o = 1'b0;
  assign flash_clk_o  = 1'b0;
  assign flash_rstn_o = rstn_q;

endmodule
